// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - two-stage unsigned multiply-accumulate producing one K-term dot product per completion
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int K      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              abort,
  output logic [ACC_W-1:0]  mac_out,
  output logic              mac_valid,
  output logic              sat,
  output logic              busy
);

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(K - 1);

  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic             p_vld_q, p_vld_d;
  logic             p_last_q, p_last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_acc_q, sat_acc_d;
  logic [ACC_W-1:0] mac_out_q, mac_out_d;
  logic             mac_valid_q, mac_valid_d;
  logic             sat_q, sat_d;

  logic [PW-1:0]    mult;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] result;

  assign mult   = PW'(a_in) * PW'(b_in);
  assign sum    = {1'b0, acc_q} + {1'b0, prod_q};
  assign carry  = sum[ACC_W];
  // A carry-out clamps to all-ones; later terms keep it pinned there.
  assign result = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

  always_comb begin
    term_cnt_d  = term_cnt_q;
    prod_d      = prod_q;
    p_vld_d     = 1'b0;
    p_last_d    = p_last_q;
    acc_d       = acc_q;
    sat_acc_d   = sat_acc_q;
    mac_out_d   = mac_out_q;
    mac_valid_d = 1'b0;
    sat_d       = sat_q;
    if (abort) begin
      term_cnt_d = '0;
      p_last_d   = 1'b0;
      acc_d      = '0;
      sat_acc_d  = 1'b0;
    end else begin
      if (enable) begin
        prod_d     = ACC_W'(mult);
        p_vld_d    = 1'b1;
        p_last_d   = (term_cnt_q == LAST_TERM);
        term_cnt_d = (term_cnt_q == LAST_TERM) ? '0 : term_cnt_q + CNT_W'(1);
      end
      if (p_vld_q) begin
        if (p_last_q) begin
          mac_out_d   = result;
          sat_d       = sat_acc_q | carry;
          mac_valid_d = 1'b1;
          acc_d       = '0;
          sat_acc_d   = 1'b0;
        end else begin
          acc_d     = result;
          sat_acc_d = sat_acc_q | carry;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      term_cnt_q  <= '0;
      prod_q      <= '0;
      p_vld_q     <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      sat_acc_q   <= 1'b0;
      mac_out_q   <= '0;
      mac_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      term_cnt_q  <= term_cnt_d;
      prod_q      <= prod_d;
      p_vld_q     <= p_vld_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      sat_acc_q   <= sat_acc_d;
      mac_out_q   <= mac_out_d;
      mac_valid_q <= mac_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign mac_out   = mac_out_q;
  assign mac_valid = mac_valid_q;
  assign sat       = sat_q;
  assign busy      = (term_cnt_q != '0) | p_vld_q;

endmodule

// File: tb/tb_mac_unit.sv
// tb/tb_mac_unit.sv - scoreboard bench for mac_unit with K=3, DATA_W=8, ACC_W=16
module tb_mac_unit;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int K      = 3;
  localparam int MAXV   = 65535;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              abort;
  logic [ACC_W-1:0]  mac_out;
  logic              mac_valid;
  logic              sat;
  logic              busy;

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .a_in      (a_in),
    .b_in      (b_in),
    .abort     (abort),
    .mac_out   (mac_out),
    .mac_valid (mac_valid),
    .sat       (sat),
    .busy      (busy)
  );

  typedef struct {
    int val;
    int s;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   m_sum = 0;
  int   m_terms = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One input cycle: operands land at the next posedge; a completed dot
  // product shows up on the negedge two cycles after this one.
  task automatic drive(input bit en, input int a, input int b, input bit ab);
    exp_t e;
    @(negedge clk);
    enable = en;
    a_in   = DATA_W'(a);
    b_in   = DATA_W'(b);
    abort  = ab;
    if (ab) begin
      m_sum   = 0;
      m_terms = 0;
      if (sb.size() > 0 && sb[$].cyc == cyc + 1) void'(sb.pop_back());
    end else if (en) begin
      m_sum += a * b;
      m_terms++;
      if (m_terms == K) begin
        e.s   = (m_sum > MAXV) ? 1 : 0;
        e.val = (m_sum > MAXV) ? MAXV : m_sum;
        e.cyc = cyc + 2;
        sb.push_back(e);
        m_sum   = 0;
        m_terms = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    abort  = 1'b0;
    m_sum   = 0;
    m_terms = 0;
    sb.delete();
    @(negedge clk);
    check("rst_mac_out", int'(mac_out), 0);
    check("rst_mac_valid", int'(mac_valid), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mac_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("mac_out", int'(mac_out), e.val);
          check("sat", int'(sat), e.s);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        check("missing_pulse", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    abort  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // consecutive pairs -> 44
    drive(1, 1, 2, 0); drive(1, 3, 4, 0); drive(1, 5, 6, 0);
    idle(3);
    check("busy_idle_t1", int'(busy), 0);

    // gapped pairs -> 44, busy held through the gaps
    drive(1, 1, 2, 0);
    idle(1); check("busy_gap1", int'(busy), 1);
    idle(1); check("busy_gap2", int'(busy), 1);
    drive(1, 3, 4, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("busy_gap3", int'(busy), 1);
    end
    drive(1, 5, 6, 0);
    idle(4);

    // saturation then recovery
    for (int i = 0; i < 3; i++) drive(1, 255, 255, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0);
    idle(4);

    // back-to-back dot products -> 14, 77
    for (int i = 1; i <= 6; i++) drive(1, i, i, 0);
    idle(4);

    // abort with enable mid-product
    drive(1, 7, 7, 0); drive(1, 7, 7, 0);
    drive(1, 9, 9, 1);
    drive(1, 1, 2, 0); drive(1, 3, 4, 0); drive(1, 5, 6, 0);
    idle(4);

    // abort right after the last term drops the in-flight result
    for (int i = 0; i < 3; i++) drive(1, 10, 10, 0);
    drive(0, 0, 0, 1);
    idle(4);
    check("mac_out_held", int'(mac_out), 44);

    // reset after two terms -> outputs cleared, no pulse
    drive(1, 8, 8, 0); drive(1, 8, 8, 0);
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 2, 3, 0);
    idle(4);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
